sync_rr_merge8_arbiter: RTL and testbench
=========================================

# sync_rr_merge8_arbiter

Clocked 8-way round-robin arbiter that shares one downstream drive/free channel among eight requesters. It is the synchronous counterpart of the mutex-merge controllers. It latches drive pulses as pending requests and grants exactly one requester at a time. It forwards that requester's data with a one-cycle drive pulse, then returns the downstream free pulse to the granted requester only. It also adds fairness, a response watchdog and protocol-error flagging at the boundary between clocked blocks and the async merge fabric.

## Interface
- DATA_WIDTH, 32, width of each data lane
- TIMEOUT_CYCLES, 1024, cycles in WAIT before o_timeout is set; 0 disables the watchdog
- clk  input  1  sole clock, rising edge
- rstn  input  1  asynchronous active-low reset
- i_drive  input  8  per-requester drive pulse (one cycle)
- i_data  input  8*DATA_WIDTH  lane k = i_data[k*DATA_WIDTH +: DATA_WIDTH]; held stable by requester k from its drive until its free
- o_free  output  8  one-cycle free pulse to the served requester
- o_driveNext  output  1  one-cycle drive pulse to downstream
- o_data  output  DATA_WIDTH  registered data of the granted requester
- i_freeNext  input  1  one-cycle free pulse from downstream
- o_grant  output  8  one-hot current grant, 0 when idle
- o_busy  output  1  high in ISSUE or WAIT
- o_timeout  output  1  sticky watchdog flag
- o_protoErr  output  1  sticky protocol-violation flag

## Operation
- Reset values: every output is 0, pend[7:0]=0, ptr=0, state=IDLE, watchdog counter=0.
- Pending: i_drive[k] sampled high sets pend[k].
  - If pend[k] is already 1 and is not being cleared on the same edge: the pulse is ignored and o_protoErr is set.
  - If pend[k] is being cleared on the same edge: pend[k] stays 1 and this counts as a new request with no error.
- FSM IDLE: if any pend bit is set, select the first set bit searching ptr, ptr+1, … mod 8. Then register o_data from that lane, set o_grant to its one-hot, and go to ISSUE. Otherwise hold; o_data keeps its last value.
- FSM ISSUE: o_driveNext=1 for exactly this cycle; go to WAIT unconditionally.
- FSM WAIT: on i_freeNext sampled high:
  - assert o_free[g] for the next cycle;
  - clear pend[g];
  - set ptr=(g+1) mod 8;
  - clear o_grant;
  - clear the watchdog counter;
  - go to IDLE.
- i_freeNext sampled outside WAIT is ignored and sets o_protoErr.
- Watchdog: the counter increments each WAIT cycle without i_freeNext and saturates. When it reaches TIMEOUT_CYCLES (non-zero), o_timeout is set. The FSM keeps waiting; there is no auto-abort.
- o_timeout and o_protoErr clear only on reset.
- Reset mid-operation: all pending and outstanding transactions are discarded; requesters must reissue.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Timing
- i_drive[k] sampled at edge N: pend[k]=1 after N. Grant and o_data are registered at N+1. o_driveNext is high between N+1 and N+2.
- i_freeNext sampled at edge M: o_free[g] is high between M and M+1. The next grant is registered at M+1 at the earliest.
- Per-transaction occupancy is 3 cycles plus downstream latency; at most one o_driveNext in flight.
- o_data and o_grant are stable from the grant edge until the edge that samples i_freeNext.
- Fairness: a pending requester is served within 7 other grants.

## Test plan
- Single request: pulse i_drive[3] with lane3=0xA5A5A5A5; i_freeNext 4 cycles after o_driveNext. Required: o_grant=0x08, o_data=0xA5A5A5A5, o_driveNext 2 cycles after drive, o_free=0x08 one cycle after freeNext, ptr=4.
- Simultaneous: pulse i_drive=0xFF in one cycle and echo free each time. Required grant order 0,1,…,7, each with its own lane data; exactly 8 o_driveNext and 8 o_free pulses.
- Round-robin wrap: ptr=6 (after serving 5), then pend bits 1 and 7 set together. Required: 7 is served, then 1, then ptr=2.
- Protocol errors: a second i_drive[2] while pend[2] is set and not being cleared, and an i_freeNext while in IDLE. Required: o_protoErr=1, no extra grant or free, and normal service continues.
- Watchdog: TIMEOUT_CYCLES=16 and i_freeNext withheld. Required: o_timeout=1 after the 16th WAIT cycle, state remains WAIT, and a late i_freeNext still completes the transaction.
- Re-request on free edge plus mid-WAIT reset: i_drive[0] sampled on the edge that clears pend[0] gives a second grant to 0 with no error. rstn low during WAIT gives all outputs 0 immediately and no o_free after release.

Source files
------------

// File: rtl/sync_rr_merge8_arbiter.sv
// Clocked 8-way round-robin arbiter sharing one downstream drive/free channel.
// Latches drive pulses as pending requests, serves one at a time, and flags watchdog and protocol faults.
module sync_rr_merge8_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [7:0]              i_drive,
    input  logic [8*DATA_WIDTH-1:0] i_data,
    output logic [7:0]              o_free,
    output logic                    o_driveNext,
    output logic [DATA_WIDTH-1:0]   o_data,
    input  logic                    i_freeNext,
    output logic [7:0]              o_grant,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic                    o_protoErr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            pend_q, pend_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            gidx_q, gidx_d;
    logic [7:0]            grant_q, grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  drive_next_q, drive_next_d;
    logic [7:0]            free_q, free_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  proto_err_q, proto_err_d;

    logic [DATA_WIDTH-1:0] lane_s [8];
    logic [3:0]            pick_s;
    logic [7:0]            pend_clr_s;
    logic [CNT_W-1:0]      cnt_inc_s;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign lane_s[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Returns {found, index} of the first set request bit at or after ptr, wrapping mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + i[2:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, pending bookkeeping, watchdog and error flag computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        data_d       = data_q;
        drive_next_d = 1'b0;
        free_d       = 8'd0;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        pend_clr_s   = 8'd0;
        pick_s       = rr_pick(pend_q, ptr_q);
        cnt_inc_s    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        case (state_q)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    gidx_d       = pick_s[2:0];
                    grant_d      = 8'd1 << pick_s[2:0];
                    data_d       = lane_s[pick_s[2:0]];
                    drive_next_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_freeNext) begin
                    free_d     = 8'd1 << gidx_q;
                    pend_clr_s = 8'd1 << gidx_q;
                    ptr_d      = gidx_q + 3'd1;
                    grant_d    = 8'd0;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Saturating count; the flag latches the first time the limit is reached.
                    cnt_d     = cnt_inc_s;
                    timeout_d = timeout_q | (cnt_inc_s == CNT_MAX);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'd0;
            end
        endcase

        // A drive landing on the edge that frees the same requester counts as a fresh request.
        pend_d      = (pend_q & ~pend_clr_s) | i_drive;
        proto_err_d = proto_err_q
                    | (|(i_drive & pend_q & ~pend_clr_s))
                    | (i_freeNext && (state_q != ST_WAIT));
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            pend_q       <= 8'd0;
            ptr_q        <= 3'd0;
            gidx_q       <= 3'd0;
            grant_q      <= 8'd0;
            data_q       <= {DATA_WIDTH{1'b0}};
            drive_next_q <= 1'b0;
            free_q       <= 8'd0;
            busy_q       <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            timeout_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            drive_next_q <= drive_next_d;
            free_q       <= free_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign o_free      = free_q;
    assign o_driveNext = drive_next_q;
    assign o_data      = data_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;
    assign o_protoErr  = proto_err_q;

endmodule

// File: tb/tb_sync_rr_merge8_arbiter.sv
// Directed self-checking bench for sync_rr_merge8_arbiter (watchdog limit set to 16 cycles).
module tb_sync_rr_merge8_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [7:0]    i_drive = 8'd0;
    logic [8*DW-1:0] i_data = '0;
    logic          i_freeNext = 1'b0;
    logic [7:0]    o_free;
    logic          o_driveNext;
    logic [DW-1:0] o_data;
    logic [7:0]    o_grant;
    logic          o_busy;
    logic          o_timeout;
    logic          o_protoErr;

    int n_tests = 0;
    int n_fail  = 0;

    sync_rr_merge8_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data),
        .o_free(o_free), .o_driveNext(o_driveNext), .o_data(o_data),
        .i_freeNext(i_freeNext), .o_grant(o_grant), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_protoErr(o_protoErr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        i_drive = 8'd0;
        i_freeNext = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic pulse_free;
        i_freeNext = 1'b1;
        tick();
        i_freeNext = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        tick();
        n_tests++;
        if ({o_free, o_driveNext, o_grant, o_busy, o_timeout, o_protoErr} !== 20'd0 || o_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got free=%h drv=%b grant=%h busy=%b to=%b pe=%b data=%h want all 0",
                     o_free, o_driveNext, o_grant, o_busy, o_timeout, o_protoErr, o_data);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single;
        i_data[3*DW +: DW] = 32'hA5A5A5A5;
        i_drive = 8'h08;
        tick();
        i_drive = 8'h00;
        n_tests++;
        if (o_driveNext !== 1'b0) begin n_fail++; $display("FAIL single_drv_early: got %b want 0", o_driveNext); end
        tick();
        n_tests++;
        if (o_grant !== 8'h08) begin n_fail++; $display("FAIL single_grant: got %h want 08", o_grant); end
        n_tests++;
        if (o_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL single_data: got %h want a5a5a5a5", o_data); end
        n_tests++;
        if (o_driveNext !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_issue: got drv=%b busy=%b want 1 1", o_driveNext, o_busy);
        end
        tick();
        n_tests++;
        if (o_driveNext !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_wait: got drv=%b busy=%b want 0 1", o_driveNext, o_busy);
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (o_data !== 32'hA5A5A5A5 || o_grant !== 8'h08) begin
            n_fail++; $display("FAIL single_hold: got data=%h grant=%h want a5a5a5a5 08", o_data, o_grant);
        end
        pulse_free();
        n_tests++;
        if (o_free !== 8'h08 || o_grant !== 8'h00 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_free: got free=%h grant=%h busy=%b want 08 00 0", o_free, o_grant, o_busy);
        end
        n_tests++;
        if (dut.ptr_q !== 3'd4) begin n_fail++; $display("FAIL single_ptr: got %0d want 4", dut.ptr_q); end
        tick();
        n_tests++;
        if (o_free !== 8'h00) begin n_fail++; $display("FAIL single_free_width: got %h want 00", o_free); end
    endtask

    task automatic test_simultaneous;
        int n_drv;
        int n_free;
        logic [7:0] exp_g;
        n_drv = 0;
        n_free = 0;
        apply_reset();
        for (int k = 0; k < 8; k++) i_data[k*DW +: DW] = 32'hC0DE0000 + 32'(k);
        i_drive = 8'hFF;
        tick();
        i_drive = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp_g = 8'h01 << k;
            tick();
            if (o_driveNext === 1'b1) n_drv++;
            n_tests++;
            if (o_grant !== exp_g || o_data !== 32'hC0DE0000 + 32'(k)) begin
                n_fail++; $display("FAIL simul_grant%0d: got grant=%h data=%h want %h %h",
                                   k, o_grant, o_data, exp_g, 32'hC0DE0000 + 32'(k));
            end
            tick();
            if (o_driveNext === 1'b1) n_drv++;
            pulse_free();
            if (o_driveNext === 1'b1) n_drv++;
            if (o_free !== 8'h00) n_free++;
            n_tests++;
            if (o_free !== exp_g) begin n_fail++; $display("FAIL simul_free%0d: got %h want %h", k, o_free, exp_g); end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_driveNext === 1'b1) n_drv++;
            if (o_free !== 8'h00) n_free++;
        end
        n_tests++;
        if (n_drv !== 8 || n_free !== 8) begin
            n_fail++; $display("FAIL simul_counts: got drv=%0d free=%0d want 8 8", n_drv, n_free);
        end
        n_tests++;
        if (o_grant !== 8'h00 || o_protoErr !== 1'b0) begin
            n_fail++; $display("FAIL simul_idle: got grant=%h pe=%b want 00 0", o_grant, o_protoErr);
        end
    endtask

    task automatic test_wrap;
        i_drive = 8'h20;
        tick();
        i_drive = 8'h00;
        tick();
        tick();
        pulse_free();
        n_tests++;
        if (dut.ptr_q !== 3'd6) begin n_fail++; $display("FAIL wrap_ptr6: got %0d want 6", dut.ptr_q); end
        i_drive = 8'h82;
        tick();
        i_drive = 8'h00;
        tick();
        n_tests++;
        if (o_grant !== 8'h80 || o_data !== 32'hC0DE0007) begin
            n_fail++; $display("FAIL wrap_first: got grant=%h data=%h want 80 c0de0007", o_grant, o_data);
        end
        tick();
        pulse_free();
        n_tests++;
        if (o_free !== 8'h80) begin n_fail++; $display("FAIL wrap_free7: got %h want 80", o_free); end
        tick();
        n_tests++;
        if (o_grant !== 8'h02 || o_data !== 32'hC0DE0001) begin
            n_fail++; $display("FAIL wrap_second: got grant=%h data=%h want 02 c0de0001", o_grant, o_data);
        end
        tick();
        pulse_free();
        n_tests++;
        if (o_free !== 8'h02 || dut.ptr_q !== 3'd2) begin
            n_fail++; $display("FAIL wrap_end: got free=%h ptr=%0d want 02 2", o_free, dut.ptr_q);
        end
    endtask

    task automatic test_proto_err;
        apply_reset();
        pulse_free();
        n_tests++;
        if (o_protoErr !== 1'b1 || o_free !== 8'h00 || o_grant !== 8'h00) begin
            n_fail++; $display("FAIL proto_idle_free: got pe=%b free=%h grant=%h want 1 00 00", o_protoErr, o_free, o_grant);
        end
        apply_reset();
        n_tests++;
        if (o_protoErr !== 1'b0) begin n_fail++; $display("FAIL proto_cleared: got %b want 0", o_protoErr); end
        i_drive = 8'h04;
        tick();
        tick();
        i_drive = 8'h00;
        n_tests++;
        if (o_protoErr !== 1'b1 || o_grant !== 8'h04) begin
            n_fail++; $display("FAIL proto_dup_drive: got pe=%b grant=%h want 1 04", o_protoErr, o_grant);
        end
        tick();
        pulse_free();
        n_tests++;
        if (o_free !== 8'h04) begin n_fail++; $display("FAIL proto_free2: got %h want 04", o_free); end
        tick();
        tick();
        n_tests++;
        if (o_grant !== 8'h00 || o_driveNext !== 1'b0 || o_free !== 8'h00) begin
            n_fail++; $display("FAIL proto_no_extra: got grant=%h drv=%b free=%h want 00 0 00", o_grant, o_driveNext, o_free);
        end
        i_data[4*DW +: DW] = 32'h0BADF00D;
        i_drive = 8'h10;
        tick();
        i_drive = 8'h00;
        tick();
        n_tests++;
        if (o_grant !== 8'h10 || o_data !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL proto_continue: got grant=%h data=%h want 10 0badf00d", o_grant, o_data);
        end
        tick();
        pulse_free();
        n_tests++;
        if (o_free !== 8'h10) begin n_fail++; $display("FAIL proto_free4: got %h want 10", o_free); end
    endtask

    task automatic test_watchdog;
        apply_reset();
        i_drive = 8'h02;
        tick();
        i_drive = 8'h00;
        tick();
        tick();
        for (int c = 0; c < 15; c++) tick();
        n_tests++;
        if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early: got %b want 0 after 15 wait cycles", o_timeout); end
        tick();
        n_tests++;
        if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_set: got %b want 1 after 16 wait cycles", o_timeout); end
        tick();
        tick();
        n_tests++;
        if (o_busy !== 1'b1 || o_grant !== 8'h02 || o_driveNext !== 1'b0) begin
            n_fail++; $display("FAIL wd_still_wait: got busy=%b grant=%h drv=%b want 1 02 0", o_busy, o_grant, o_driveNext);
        end
        pulse_free();
        n_tests++;
        if (o_free !== 8'h02 || o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL wd_late_free: got free=%h to=%b busy=%b want 02 1 0", o_free, o_timeout, o_busy);
        end
    endtask

    task automatic test_rerequest_reset;
        n_tests++;
        if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL rr_pre_timeout: got %b want 1", o_timeout); end
        apply_reset();
        i_data[0 +: DW] = 32'h12345678;
        i_drive = 8'h01;
        tick();
        i_drive = 8'h00;
        tick();
        tick();
        i_drive = 8'h01;
        pulse_free();
        i_drive = 8'h00;
        n_tests++;
        if (o_free !== 8'h01 || o_protoErr !== 1'b0) begin
            n_fail++; $display("FAIL rr_free_edge: got free=%h pe=%b want 01 0", o_free, o_protoErr);
        end
        tick();
        n_tests++;
        if (o_grant !== 8'h01 || o_driveNext !== 1'b1 || o_protoErr !== 1'b0) begin
            n_fail++; $display("FAIL rr_regrant: got grant=%h drv=%b pe=%b want 01 1 0", o_grant, o_driveNext, o_protoErr);
        end
        tick();
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({o_free, o_driveNext, o_grant, o_busy, o_timeout, o_protoErr} !== 20'd0 || o_data !== 32'd0) begin
            n_fail++; $display("FAIL rr_async_reset: got grant=%h busy=%b data=%h want 00 0 0", o_grant, o_busy, o_data);
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (o_free !== 8'h00 || o_grant !== 8'h00 || o_driveNext !== 1'b0) begin
                n_fail++; $display("FAIL rr_after_reset%0d: got free=%h grant=%h drv=%b want 00 00 0", c, o_free, o_grant, o_driveNext);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_proto_err();
        test_watchdog();
        test_rerequest_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
